// File: rtl/sdram_refresh_arbiter_pkg.sv
// sdram_refresh_arbiter_pkg
// Shared definitions for the SDRAM refresh arbiter. It holds the arbiter
// state encoding, the default timing parameters and the saturating
// credit-update helper.
// No ports. The optional macro REFRESH_POSTPONE_EN is consumed by the top
// module, not by this package.

package sdram_refresh_arbiter_pkg;

  // Arbiter states. IDLE arbitrates, BUS/REFRESH own the sequencer and
  // RECOVER enforces the post-refresh quiet time.
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUS     = 2'd1,
    ARB_REFRESH = 2'd2,
    ARB_RECOVER = 2'd3
  } arb_state_t;

  // 64 ms / 4096 rows at 25 MHz.
  localparam int REFRESH_INTERVAL_DEFAULT = 390;
  localparam int MAX_PENDING_DEFAULT      = 8;
  localparam int T_RECOVER_DEFAULT        = 2;
  localparam int PENDING_W                = 4;

  // Saturating credit update. A simultaneous increment and decrement cancel.
  // The counter never wraps past max or below zero.
  function automatic logic [PENDING_W-1:0] credit_next(
    input logic [PENDING_W-1:0] cur,
    input logic                 inc,
    input logic                 dec,
    input logic [PENDING_W-1:0] max
  );
    logic [PENDING_W-1:0] res;
    res = cur;
    if (inc && !dec) begin
      if (cur != max) res = cur + PENDING_W'(1);
      else            res = cur;
    end else if (dec && !inc) begin
      if (cur != {PENDING_W{1'b0}}) res = cur - PENDING_W'(1);
      else                          res = cur;
    end else begin
      res = cur;
    end
    return res;
  endfunction

endpackage

// File: rtl/sdram_refresh_arbiter_refresh_timer.sv
// sdram_refresh_arbiter_refresh_timer
// Free-running refresh interval counter. It counts 0..INTERVAL-1 while
// init_done is high and emits a one-cycle tick on the wrap. While init_done
// is low the counter is held at 0, so no tick can occur before the SDRAM is
// initialised.
// Ports:
//   MEMCLK     in  clock
//   RESET_n    in  synchronous reset, active low
//   init_done  in  SDRAM init complete (level)
//   tick       out one-cycle pulse on every interval wrap

module sdram_refresh_arbiter_refresh_timer
  import sdram_refresh_arbiter_pkg::*;
#(
  parameter int INTERVAL = REFRESH_INTERVAL_DEFAULT
) (
  input  logic MEMCLK,
  input  logic RESET_n,
  input  logic init_done,
  output logic tick
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [TW-1:0] LAST = TW'(INTERVAL - 1);

  logic [TW-1:0] count;

  // Interval counter, cleared by reset and held at zero until init is done.
  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      count <= '0;
    end else if (!init_done) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + TW'(1);
    end
  end

  // The tick is decoded from the counter register and gated so that a stale
  // count cannot tick in the cycle in which init_done drops.
  assign tick = init_done && (count == LAST);

endmodule

// File: rtl/sdram_refresh_arbiter.sv
// sdram_refresh_arbiter
// Shares the SDRAM command sequencer between Zorro II RAM cycles and
// periodic auto-refresh. The module owns the refresh credit counter, the
// grant FSM and the post-refresh recovery counter. The interval timer lives
// in sdram_refresh_arbiter_refresh_timer.
//
// Optional macro REFRESH_POSTPONE_EN:
//   defined   -> bus cycles may postpone refresh until MAX_PENDING credits
//                are owed.
//   undefined -> credits saturate at 1 and any owed refresh beats a bus
//                request in IDLE.
//
// Ports:
//   MEMCLK        in   clock
//   RESET_n       in   synchronous reset, active low
//   init_done     in   SDRAM power-up init complete (level)
//   bus_req       in   RAM cycle requested (level)
//   bus_done      in   pulse: bus cycle finished
//   ref_done      in   pulse: refresh command finished
//   bus_gnt       out  bus cycle may run; held until bus_done
//   ref_gnt       out  refresh may run; held until ref_done
//   ref_pending   out  [3:0] refresh credits owed
//   ref_overflow  out  sticky: a tick arrived with credits saturated

module sdram_refresh_arbiter
  import sdram_refresh_arbiter_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT,
  parameter int MAX_PENDING      = MAX_PENDING_DEFAULT,
  parameter int T_RECOVER        = T_RECOVER_DEFAULT
) (
  input  logic                 MEMCLK,
  input  logic                 RESET_n,
  input  logic                 init_done,
  input  logic                 bus_req,
  input  logic                 bus_done,
  input  logic                 ref_done,
  output logic                 bus_gnt,
  output logic                 ref_gnt,
  output logic [PENDING_W-1:0] ref_pending,
  output logic                 ref_overflow
);

`ifdef REFRESH_POSTPONE_EN
  localparam int MAX_EFF = MAX_PENDING;
`else
  // Without postponement a single owed refresh already counts as saturated.
  localparam int MAX_EFF = (MAX_PENDING < 1) ? MAX_PENDING : 1;
`endif

  localparam logic [PENDING_W-1:0] PEND_MAX = PENDING_W'(MAX_EFF);
  localparam int RW = (T_RECOVER > 1) ? $clog2(T_RECOVER) : 1;
  localparam logic [RW-1:0] REC_LAST = RW'(T_RECOVER - 1);

  arb_state_t    state;
  arb_state_t    state_next;
  logic          tick;
  logic [RW-1:0] rec_cnt;
  logic          rec_done;

  sdram_refresh_arbiter_refresh_timer #(
    .INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .MEMCLK    (MEMCLK),
    .RESET_n   (RESET_n),
    .init_done (init_done),
    .tick      (tick)
  );

  // Credit counter and sticky overflow flag. A tick that arrives while the
  // credits are saturated, with no ref_done to cancel it, is lost and
  // flagged.
  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      ref_pending  <= '0;
      ref_overflow <= 1'b0;
    end else begin
      ref_pending <= credit_next(ref_pending, tick, ref_done, PEND_MAX);
      if (tick && !ref_done && (ref_pending == PEND_MAX)) begin
        ref_overflow <= 1'b1;
      end else begin
        ref_overflow <= ref_overflow;
      end
    end
  end

  // Recovery counter. It runs only in RECOVER and is cleared everywhere else.
  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      rec_cnt <= '0;
    end else if ((state == ARB_RECOVER) && !rec_done) begin
      rec_cnt <= rec_cnt + RW'(1);
    end else begin
      rec_cnt <= '0;
    end
  end

  assign rec_done = (rec_cnt == REC_LAST);

  // State register.
  always_ff @(posedge MEMCLK) begin
    if (!RESET_n) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Grants are released only by their own done pulse, so a
  // grant never changes in the middle of a cycle. Saturated credits take
  // priority over a bus request.
  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (!init_done) begin
          state_next = ARB_IDLE;
        end else if (ref_pending == PEND_MAX) begin
          state_next = ARB_REFRESH;
        end else if (bus_req) begin
          state_next = ARB_BUS;
        end else if (ref_pending != {PENDING_W{1'b0}}) begin
          state_next = ARB_REFRESH;
        end else begin
          state_next = ARB_IDLE;
        end
      end
      ARB_BUS: begin
        if (bus_done) state_next = ARB_IDLE;
        else          state_next = ARB_BUS;
      end
      ARB_REFRESH: begin
        if (ref_done) state_next = ARB_RECOVER;
        else          state_next = ARB_REFRESH;
      end
      ARB_RECOVER: begin
        if (rec_done) state_next = ARB_IDLE;
        else          state_next = ARB_RECOVER;
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  // Output decode. The grants come straight from the state register, so they
  // are glitch-free and mutually exclusive by construction.
  always_comb begin
    bus_gnt = 1'b0;
    ref_gnt = 1'b0;
    case (state)
      ARB_BUS:     bus_gnt = 1'b1;
      ARB_REFRESH: ref_gnt = 1'b1;
      default: begin
        bus_gnt = 1'b0;
        ref_gnt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sdram_refresh_arbiter.sv
// tb_sdram_refresh_arbiter
// Self-checking bench for sdram_refresh_arbiter. A cycle-level reference
// model, built from the credit and priority rules, runs alongside the DUT.
// A responder answers grants with done pulses. Honours REFRESH_POSTPONE_EN
// in the same way as the design.

module tb_sdram_refresh_arbiter;

  localparam int INTERVAL = 390;
  localparam int TREC     = 2;
`ifdef REFRESH_POSTPONE_EN
  localparam int MAXE = 8;
`else
  localparam int MAXE = 1;
`endif

  logic       MEMCLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       init_done = 1'b0;
  logic       bus_req = 1'b0;
  logic       bus_done = 1'b0;
  logic       ref_done = 1'b0;
  logic       bus_gnt;
  logic       ref_gnt;
  logic [3:0] ref_pending;
  logic       ref_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  sdram_refresh_arbiter dut (
    .MEMCLK       (MEMCLK),
    .RESET_n      (RESET_n),
    .init_done    (init_done),
    .bus_req      (bus_req),
    .bus_done     (bus_done),
    .ref_done     (ref_done),
    .bus_gnt      (bus_gnt),
    .ref_gnt      (ref_gnt),
    .ref_pending  (ref_pending),
    .ref_overflow (ref_overflow)
  );

  always #5 MEMCLK = ~MEMCLK;

  // Reference model. m_age counts consecutive initialised cycles, m_owner
  // records who holds the sequencer (0 none, 1 bus, 2 refresh) and m_hold
  // counts the quiet cycles that remain after a refresh.
  int m_age = 0, m_pend = 0, m_owner = 0, m_hold = 0;
  bit m_ovf = 1'b0;

  always @(posedge MEMCLK) begin
    if (!RESET_n) begin
      m_age <= 0; m_pend <= 0; m_owner <= 0; m_hold <= 0; m_ovf <= 1'b0;
    end else begin
      automatic bit tk = init_done && (((m_age + 1) % INTERVAL) == 0);
      automatic int p = m_pend;
      m_age <= init_done ? m_age + 1 : 0;
      if (tk && !ref_done) begin
        if (m_pend == MAXE) m_ovf <= 1'b1;
        p = (m_pend + 1 > MAXE) ? MAXE : m_pend + 1;
      end else if (ref_done && !tk) begin
        p = (m_pend > 0) ? m_pend - 1 : 0;
      end
      m_pend <= p;
      if (m_owner == 1) begin
        if (bus_done) m_owner <= 0;
      end else if (m_owner == 2) begin
        if (ref_done) begin m_owner <= 0; m_hold <= TREC; end
      end else if (m_hold > 0) begin
        m_hold <= m_hold - 1;
      end else if (init_done) begin
        if (m_pend == MAXE)   m_owner <= 2;
        else if (bus_req)     m_owner <= 1;
        else if (m_pend > 0)  m_owner <= 2;
      end
    end
  end

  // Responder state, driven only by step().
  bit auto_bus = 0, auto_ref = 0, rand_lat = 0;
  int bus_lat = 20, ref_lat = 3, bus_cnt = 0, ref_cnt = 0;

  // Advance n cycles. Inputs change at the negedge and the automatic
  // responder issues done pulses.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge MEMCLK);
      bus_done = 1'b0;
      ref_done = 1'b0;
      if (auto_bus && bus_gnt) begin
        bus_cnt++;
        if (bus_cnt >= bus_lat) begin
          bus_done = 1'b1; bus_cnt = 0;
          if (rand_lat) bus_lat = $urandom_range(1, 8);
        end
      end else bus_cnt = 0;
      if (auto_ref && ref_gnt) begin
        ref_cnt++;
        if (ref_cnt >= ref_lat) begin
          ref_done = 1'b1; ref_cnt = 0;
          if (rand_lat) ref_lat = $urandom_range(1, 5);
        end
      end else ref_cnt = 0;
    end
  endtask

  task automatic do_reset();
    RESET_n = 1'b0; init_done = 1'b0; bus_req = 1'b0;
    auto_bus = 0; auto_ref = 0; rand_lat = 0;
    step(3);
    RESET_n = 1'b1;
  endtask

  task automatic test_reset();
    int bad = 0;
    RESET_n = 1'b0; init_done = 1'b0; bus_req = 1'b1;
    step(2);
    n_checks++;
    if ({bus_gnt, ref_gnt, ref_pending, ref_overflow} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_state got gnt=%b%b pend=%0d ovf=%b want all 0",
               bus_gnt, ref_gnt, ref_pending, ref_overflow);
    end
    RESET_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      step(1);
      if ({bus_gnt, ref_gnt, ref_pending, ref_overflow} !== 7'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL init_low_idle got %0d active cycles want 0", bad);
    end
    bus_req = 1'b0;
  endtask

  task automatic test_first_refresh();
    int rise = -1;
    int brise = -1;
    do_reset();
    init_done = 1'b1;
    for (int k = 1; k <= 500 && rise < 0; k++) begin
      step(1);
      if (ref_gnt) rise = k;
    end
    n_checks++;
    if (rise !== 391) begin
      n_fail++;
      $display("FAIL first_ref_latency got cycle %0d want 391", rise);
    end
    step(2);
    ref_done = 1'b1;
    step(1);
    n_checks++;
    if ({ref_gnt, ref_pending} !== 5'b0) begin
      n_fail++;
      $display("FAIL ref_release got ref_gnt=%b pend=%0d want 0/0", ref_gnt, ref_pending);
    end
    bus_req = 1'b1;
    for (int k = 1; k <= 10 && brise < 0; k++) begin
      step(1);
      if (bus_gnt) brise = k;
    end
    n_checks++;
    if (brise !== 3) begin
      n_fail++;
      $display("FAIL recover_gap got bus grant after %0d cycles want 3", brise);
    end
    bus_done = 1'b1; bus_req = 1'b0;
    step(2);
  endtask

  task automatic test_bus_postpone();
    int maxp = 0;
    int first_ref = -1;
    int lo = MAXE * INTERVAL;
    do_reset();
    init_done = 1'b1; bus_req = 1'b1;
    auto_bus = 1; bus_lat = 20; auto_ref = 1; ref_lat = 3;
    for (int k = 1; k <= 9 * INTERVAL + 200; k++) begin
      step(1);
      n_checks++;
      if ({bus_gnt, ref_gnt, ref_pending, ref_overflow} !==
          {m_owner == 1, m_owner == 2, 4'(m_pend), m_ovf}) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL postpone_model cyc=%0d got gnt=%b%b pend=%0d ovf=%b want gnt=%b%b pend=%0d ovf=%b",
                   k, bus_gnt, ref_gnt, ref_pending, ref_overflow,
                   m_owner == 1, m_owner == 2, m_pend, m_ovf);
      end
      if (int'(ref_pending) > maxp) maxp = int'(ref_pending);
      if (ref_gnt && first_ref < 0) first_ref = k;
    end
    n_checks++;
    if (maxp !== MAXE) begin
      n_fail++;
      $display("FAIL postpone_peak got %0d want %0d", maxp, MAXE);
    end
    n_checks++;
    if (first_ref < lo || first_ref > lo + 40) begin
      n_fail++;
      $display("FAIL postpone_first_ref got cycle %0d want %0d..%0d", first_ref, lo, lo + 40);
    end
    auto_bus = 0; auto_ref = 0; bus_req = 1'b0;
  endtask

  task automatic test_tick_and_done();
    int t = (MAXE >= 3) ? 3 : MAXE;
    do_reset();
    init_done = 1'b1; bus_req = 1'b1;
    step(INTERVAL * (t + 1) - 1);
    n_checks++;
    if (int'(ref_pending) !== t) begin
      n_fail++;
      $display("FAIL pend_before_tick got %0d want %0d", ref_pending, t);
    end
    ref_done = 1'b1;
    step(1);
    n_checks++;
    if ({ref_pending, ref_overflow} !== {4'(t), 1'b0}) begin
      n_fail++;
      $display("FAIL tick_and_done got pend=%0d ovf=%b want pend=%0d ovf=0",
               ref_pending, ref_overflow, t);
    end
    bus_done = 1'b1; bus_req = 1'b0;
    step(1);
  endtask

  task automatic test_overflow();
    do_reset();
    init_done = 1'b1; bus_req = 1'b1;
    step(9 * INTERVAL + 5);
    n_checks++;
    if ({ref_pending, ref_overflow, bus_gnt} !== {4'(MAXE), 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_set got pend=%0d ovf=%b bus_gnt=%b want pend=%0d ovf=1 bus_gnt=1",
               ref_pending, ref_overflow, bus_gnt, MAXE);
    end
    bus_done = 1'b1; bus_req = 1'b0;
    step(1);
    auto_ref = 1; ref_lat = 3;
    step(120);
    n_checks++;
    if ({ref_pending, ref_overflow} !== {4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL overflow_sticky got pend=%0d ovf=%b want pend=0 ovf=1",
               ref_pending, ref_overflow);
    end
    RESET_n = 1'b0;
    step(1);
    n_checks++;
    if (ref_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL overflow_reset got %b want 0", ref_overflow);
    end
    auto_ref = 0;
  endtask

  task automatic test_reset_mid_bus();
    int rise = -1;
    do_reset();
    init_done = 1'b1; bus_req = 1'b1;
    step(5);
    n_checks++;
    if (bus_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_bus_grant got %b want 1", bus_gnt);
    end
    RESET_n = 1'b0;
    step(1);
    n_checks++;
    if ({bus_gnt, ref_gnt, ref_pending} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_mid_bus got gnt=%b%b pend=%0d want 0", bus_gnt, ref_gnt, ref_pending);
    end
    RESET_n = 1'b1; bus_req = 1'b0;
    for (int k = 1; k <= 500 && rise < 0; k++) begin
      step(1);
      if (ref_gnt) rise = k;
    end
    n_checks++;
    if (rise !== 391) begin
      n_fail++;
      $display("FAIL timer_after_reset got cycle %0d want 391", rise);
    end
    ref_done = 1'b1;
    step(4);
  endtask

  task automatic test_random();
    int bad_onehot = 0;
    do_reset();
    init_done = 1'b1;
    auto_bus = 1; auto_ref = 1; rand_lat = 1; bus_lat = 4; ref_lat = 2;
    for (int k = 1; k <= 6000; k++) begin
      step(1);
      n_checks++;
      if ({bus_gnt, ref_gnt, ref_pending, ref_overflow} !==
          {m_owner == 1, m_owner == 2, 4'(m_pend), m_ovf}) begin
        n_fail++;
        if (n_fail < 20)
          $display("FAIL random_model cyc=%0d got gnt=%b%b pend=%0d ovf=%b want gnt=%b%b pend=%0d ovf=%b",
                   k, bus_gnt, ref_gnt, ref_pending, ref_overflow,
                   m_owner == 1, m_owner == 2, m_pend, m_ovf);
      end
      if (bus_gnt && ref_gnt) bad_onehot++;
      if ($urandom_range(0, 7) == 0) bus_req = ~bus_req;
      if (init_done && $urandom_range(0, 999) == 0) init_done = 1'b0;
      else if (!init_done && $urandom_range(0, 19) == 0) init_done = 1'b1;
      RESET_n = ($urandom_range(0, 2999) != 0);
    end
    n_checks++;
    if (bad_onehot !== 0) begin
      n_fail++;
      $display("FAIL grant_onehot got %0d overlapping cycles want 0", bad_onehot);
    end
    RESET_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_first_refresh();
    test_bus_postpone();
    test_tick_and_done();
    test_overflow();
    test_reset_mid_bus();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
